// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake,
// optional one-entry skid buffer, flush-to-bubble and stall counter.
module pipe_stage_reg #(
    parameter int                 WIDTH       = 64,
    parameter logic [WIDTH-1:0]   BUBBLE_VAL  = {32'h0000_0000, 32'h0000_0013},
    parameter bit                 SKID        = 1'b1,
    parameter int                 STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;
    logic             stalled;

    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE_VAL;

    // With a skid entry, in_ready comes from state only; without one,
    // it looks through to out_ready so a full stage can still stream.
    assign in_ready  = SKID ? (state != SKIDF) : (!out_valid || out_ready);

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign stalled   = out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= BUBBLE_VAL;
            skid_q    <= BUBBLE_VAL;
            stall_cnt <= '0;
        end else begin
            if (stalled && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;

            if (flush) begin
                state <= EMPTY;
            end else if (!SKID) begin
                if (in_fire) begin
                    state  <= FULL;
                    main_q <= in_data;
                end else if (out_fire) begin
                    state <= EMPTY;
                end
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            state  <= FULL;
                            main_q <= in_data;
                        end
                    end
                    FULL: begin
                        if (in_fire && out_ready) begin
                            main_q <= in_data;
                        end else if (in_fire) begin
                            state  <= SKIDF;
                            skid_q <= in_data;
                        end else if (out_ready) begin
                            state <= EMPTY;
                        end
                    end
                    SKIDF: begin
                        if (out_ready) begin
                            state  <= FULL;
                            main_q <= skid_q;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: skid mode,
// single-entry mode and a narrow saturating stall counter.
module tb_pipe_stage_reg;

    localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // u0: SKID=1, 32-bit counter
    logic        f0 = 0, iv0 = 0, or0 = 0;
    logic [63:0] id0 = '0;
    logic        ir0, ov0;
    logic [63:0] od0;
    logic [31:0] sc0;

    // u1: SKID=0
    logic        f1 = 0, iv1 = 0, or1 = 0;
    logic [63:0] id1 = '0;
    logic        ir1, ov1;
    logic [63:0] od1;
    logic [31:0] sc1;

    // u2: SKID=1, 4-bit counter
    logic        f2 = 0, iv2 = 0, or2 = 0;
    logic [63:0] id2 = '0;
    logic        ir2, ov2;
    logic [63:0] od2;
    logic [3:0]  sc2;

    pipe_stage_reg #(.WIDTH(64), .SKID(1'b1), .STALL_CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .flush(f0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .stall_cnt(sc0)
    );

    pipe_stage_reg #(.WIDTH(64), .SKID(1'b0), .STALL_CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .flush(f1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .stall_cnt(sc1)
    );

    pipe_stage_reg #(.WIDTH(64), .SKID(1'b1), .STALL_CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .flush(f2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2),
        .stall_cnt(sc2)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ov", 64'(ov0), 64'd0);
        chk("rst_od", od0, BUB);
        chk("rst_ir", 64'(ir0), 64'd1);
        chk("rst_sc", 64'(sc0), 64'd0);

        // streaming 1..4 at full rate
        or0 = 1; iv0 = 1;
        for (int i = 1; i <= 4; i++) begin
            id0 = 64'(i);
            tick();
            chk("str_od", od0, 64'(i));
            chk("str_ov", 64'(ov0), 64'd1);
            chk("str_ir", 64'(ir0), 64'd1);
        end
        iv0 = 0;
        tick();
        chk("str_drain_ov", 64'(ov0), 64'd0);
        chk("str_sc", 64'(sc0), 64'd0);

        // skid fill
        or0 = 0; iv0 = 1; id0 = 64'hA;
        tick();
        chk("sk_a_od", od0, 64'hA);
        chk("sk_a_ir", 64'(ir0), 64'd1);
        chk("sk_a_sc", 64'(sc0), 64'd0);
        id0 = 64'hB;
        tick();
        chk("sk_b_ir", 64'(ir0), 64'd0);
        chk("sk_b_od", od0, 64'hA);
        chk("sk_b_sc", 64'(sc0), 64'd1);
        iv0 = 0;
        tick();
        chk("sk_hold_od", od0, 64'hA);
        chk("sk_hold_sc", 64'(sc0), 64'd2);
        chk("sk_hold_ir", 64'(ir0), 64'd0);
        // drain: A taken this cycle, B follows
        or0 = 1;
        chk("sk_drain_a", od0, 64'hA);
        tick();
        chk("sk_drain_b", od0, 64'hB);
        chk("sk_drain_ir", 64'(ir0), 64'd1);
        chk("sk_drain_sc", 64'(sc0), 64'd2);
        tick();
        chk("sk_empty_ov", 64'(ov0), 64'd0);

        // flush with two beats held
        or0 = 0; iv0 = 1; id0 = 64'hD;
        tick();
        chk("fl_d_sc", 64'(sc0), 64'd2);
        id0 = 64'hE;
        tick();
        chk("fl_skidf_ir", 64'(ir0), 64'd0);
        chk("fl_sc3", 64'(sc0), 64'd3);
        f0 = 1; id0 = 64'hC;
        tick();
        f0 = 0; iv0 = 0;
        chk("fl_ov", 64'(ov0), 64'd0);
        chk("fl_od", od0, BUB);
        chk("fl_sc4", 64'(sc0), 64'd4);
        tick();
        chk("fl_noc_ov", 64'(ov0), 64'd0);
        chk("fl_sc_keep", 64'(sc0), 64'd4);

        // flush from FULL drops the beat handshaked on the flush cycle
        iv0 = 1; id0 = 64'hF;
        tick();
        chk("fl2_f_od", od0, 64'hF);
        id0 = 64'hC; f0 = 1;
        chk("fl2_ir", 64'(ir0), 64'd1);
        tick();
        f0 = 0; iv0 = 0;
        chk("fl2_ov", 64'(ov0), 64'd0);
        chk("fl2_od", od0, BUB);
        or0 = 1;
        tick();
        chk("fl2_noc", 64'(ov0), 64'd0);

        // single-entry mode
        iv1 = 1; id1 = 64'h11; or1 = 0;
        #1;
        chk("se_ir_empty", 64'(ir1), 64'd1);
        tick();
        chk("se_od11", od1, 64'h11);
        chk("se_ir_blk", 64'(ir1), 64'd0);
        id1 = 64'h22;
        tick();
        chk("se_hold_od", od1, 64'h11);
        or1 = 1;
        #1;
        chk("se_ir_comb", 64'(ir1), 64'd1);
        tick();
        chk("se_od22", od1, 64'h22);
        chk("se_ov22", 64'(ov1), 64'd1);
        chk("se_sc", 64'(sc1), 64'd1);
        iv1 = 0;
        tick();
        chk("se_empty", 64'(ov1), 64'd0);
        chk("se_bub", od1, BUB);

        // saturation then reset mid-stall
        iv2 = 1; id2 = 64'h77; or2 = 0;
        tick();
        iv2 = 0;
        chk("sat_load_sc", 64'(sc2), 64'd0);
        repeat (14) tick();
        chk("sat_14", 64'(sc2), 64'd14);
        repeat (6) tick();
        chk("sat_15", 64'(sc2), 64'd15);
        chk("sat_od", od2, 64'h77);
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_ov", 64'(ov2), 64'd0);
        chk("mrst_od", od2, BUB);
        chk("mrst_ir", 64'(ir2), 64'd1);
        chk("mrst_sc", 64'(sc2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
